// File: rtl/elastic_shift_pipe.sv
// elastic_shift_pipe
//   Stallable shift pipeline of DEPTH registered stages, each WIDTH bits wide
//   with its own valid bit. Words move one stage per cycle when nothing is
//   stalled. Under backpressure a word still advances into an empty
//   downstream stage, so gaps close up. A synchronous flush clears every stage.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   flush      synchronous clear of all stages; blocks input that cycle
//   in_valid   producer offers in_data
//   in_data    input word
//   in_ready   pipe accepts in_data this cycle (combinational)
//   out_valid  last stage holds a valid word (registered)
//   out_data   data register of the last stage (registered)
//   out_ready  consumer accepts out_data this cycle
//   count      number of valid stages, 0..DEPTH (registered)
module elastic_shift_pipe #(
   parameter int unsigned     WIDTH     = 2,
   parameter int unsigned     DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int unsigned    CW        = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CW-1:0]    count
);

   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_d;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] d_d [DEPTH];
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   // free[i]: stage i may take a new value this cycle, either because it is
   // empty or because its own word moves on downstream.
   logic [DEPTH-1:0] free;
   // Valid bit / data word presented to each stage by its upstream neighbour.
   logic [DEPTH-1:0] up_v;
   logic [WIDTH-1:0] up_d [DEPTH];

   logic in_hs;
   logic out_hs;

   // Ready ripples from the output back toward the input.
   always_comb begin
      free = '0;
      free[DEPTH-1] = !v_q[DEPTH-1] || out_ready;
      for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
         free[i] = !v_q[i] || free[i+1];
      end
   end

   assign in_ready = free[0] && !flush;
   assign in_hs    = in_valid && in_ready;
   assign out_hs   = v_q[DEPTH-1] && out_ready;

   genvar gi;
   generate
      for (gi = 0; gi < int'(DEPTH); gi++) begin : g_up
         if (gi == 0) begin : g_head
            assign up_v[gi] = in_hs;
            assign up_d[gi] = in_data;
         end else begin : g_body
            assign up_v[gi] = v_q[gi-1];
            assign up_d[gi] = d_q[gi-1];
         end
      end
   endgenerate

   always_comb begin
      v_d = v_q;
      for (int i = 0; i < int'(DEPTH); i++) begin
         d_d[i] = d_q[i];
      end
      if (flush) begin
         v_d = '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            d_d[i] = RESET_VAL;
         end
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (free[i]) begin
               v_d[i] = up_v[i];
               // Empty stages keep their stale data; only real words load.
               if (up_v[i]) begin
                  d_d[i] = up_d[i];
               end
            end
         end
      end
   end

   // Occupancy tracks handshakes; simultaneous in/out leaves it unchanged.
   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else begin
         count_d = count_q + CW'(in_hs) - CW'(out_hs);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v_q     <= '0;
         count_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            d_q[i] <= RESET_VAL;
         end
      end else begin
         v_q     <= v_d;
         count_q <= count_d;
         for (int i = 0; i < int'(DEPTH); i++) begin
            d_q[i] <= d_d[i];
         end
      end
   end

   assign out_valid = v_q[DEPTH-1];
   assign out_data  = d_q[DEPTH-1];
   assign count     = count_q;

endmodule

// File: tb/tb_elastic_shift_pipe.sv
// tb_elastic_shift_pipe
//   Directed bench for elastic_shift_pipe. A WIDTH=8 / DEPTH=4 / RESET_VAL=A5
//   instance covers streaming, stall with bubble collapse, full pass-through,
//   flush and mid-stream reset; a DEPTH=1 instance covers the single-stage
//   case. Accepted words go into a scoreboard queue and are compared in order
//   as the pipe hands them out.
module tb_elastic_shift_pipe;

   logic       clk;
   logic       reset_n;

   // DEPTH = 4 instance
   logic       flush;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [2:0] count;

   // DEPTH = 1 instance
   logic       s_flush;
   logic       s_in_valid;
   logic [7:0] s_in_data;
   logic       s_in_ready;
   logic       s_out_valid;
   logic [7:0] s_out_data;
   logic       s_out_ready;
   logic [0:0] s_count;

   int         total;
   int         passed;
   int         cyc;
   logic [7:0] q    [$];
   int         qc   [$];
   logic [7:0] q1   [$];

   elastic_shift_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count)
   );

   elastic_shift_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hA5)) dut1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (s_flush),
      .in_valid  (s_in_valid),
      .in_data   (s_in_data),
      .in_ready  (s_in_ready),
      .out_valid (s_out_valid),
      .out_data  (s_out_data),
      .out_ready (s_out_ready),
      .count     (s_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock of the DEPTH=4 pipe. Called just after a rising edge; inputs
   // settle, handshakes are judged before the next edge, count after it.
   // exp_rdy < 0 means in_ready is not checked this cycle.
   task automatic step(input logic iv, input logic [7:0] id, input logic ordy,
                       input logic fl, input int exp_rdy);
      logic       acc;
      logic       pop;
      logic [7:0] e;
      int         ec;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      #1;
      if (exp_rdy >= 0) chk("in_ready", {31'd0, in_ready}, exp_rdy);
      acc = iv && in_ready;
      pop = out_valid && ordy;
      if (pop) begin
         chk("out_expected", {31'd0, q.size() != 0}, 32'd1);
         if (q.size() != 0) begin
            e  = q.pop_front();
            ec = qc.pop_front();
            chk("out_data", {24'd0, out_data}, {24'd0, e});
            if (e == 8'h01 || e == 8'h33) chk("latency", cyc - ec, 32'd4);
         end
      end
      if (fl) begin
         q.delete();
         qc.delete();
      end else if (acc) begin
         q.push_back(id);
         qc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("count", {29'd0, count}, q.size());
   endtask

   // One clock of the DEPTH=1 pipe.
   task automatic step1(input logic iv, input logic [7:0] id, input logic ordy);
      logic acc;
      logic pop;
      logic [7:0] e;
      s_in_valid  = iv;
      s_in_data   = id;
      s_out_ready = ordy;
      #1;
      chk("d1_in_ready", {31'd0, s_in_ready}, {31'd0, !s_out_valid || ordy});
      acc = iv && s_in_ready;
      pop = s_out_valid && ordy;
      if (pop) begin
         chk("d1_out_expected", {31'd0, q1.size() != 0}, 32'd1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("d1_out_data", {24'd0, s_out_data}, {24'd0, e});
         end
      end
      if (acc) q1.push_back(id);
      @(posedge clk);
      #1;
      chk("d1_count", {31'd0, s_count}, q1.size());
   endtask

   initial begin
      total = 0; passed = 0; cyc = 0;
      flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
      s_flush = 0; s_in_valid = 0; s_in_data = 0; s_out_ready = 0;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'hA5);
      chk("rst_count", {29'd0, count}, 32'd0);
      reset_n = 1'b1;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Streaming 01..08 with the consumer always ready.
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 8'(k), 1'b1, 1'b0, 1);
         if (k == 4 || k == 8) chk("stream_count", {29'd0, count}, 32'd4);
      end
      for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1, 1'b0, -1);
      chk("stream_drained", q.size(), 32'd0);

      // Stall with a gap: the bubble must collapse.
      step(1'b1, 8'h10, 1'b0, 1'b0, 1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1);
      step(1'b1, 8'h11, 1'b0, 1'b0, 1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1);
      chk("stall_count", {29'd0, count}, 32'd2);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_out_data", {24'd0, out_data}, 32'h10);
      step(1'b1, 8'h12, 1'b0, 1'b0, 1);
      step(1'b1, 8'h13, 1'b0, 1'b0, 1);
      // Full and stalled: input must be refused.
      step(1'b1, 8'hEE, 1'b0, 1'b0, 0);
      chk("full_count", {29'd0, count}, 32'd4);

      // Full pass-through.
      for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h20 + k), 1'b1, 1'b0, 1);
      chk("pass_count", {29'd0, count}, 32'd4);

      // Flush with three words in flight.
      step(1'b0, 8'h00, 1'b1, 1'b0, -1);
      chk("pre_flush_count", {29'd0, count}, 32'd3);
      step(1'b1, 8'h55, 1'b0, 1'b1, 0);
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_out_data", {24'd0, out_data}, 32'hA5);
      step(1'b1, 8'h33, 1'b1, 1'b0, 1);
      for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1, 1'b0, -1);
      chk("flush_drained", q.size(), 32'd0);

      // Mid-stream asynchronous reset with three words in flight.
      step(1'b1, 8'h41, 1'b0, 1'b0, 1);
      step(1'b1, 8'h42, 1'b0, 1'b0, 1);
      step(1'b1, 8'h43, 1'b0, 1'b0, 1);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_out_data", {24'd0, out_data}, 32'hA5);
      chk("async_rst_count", {29'd0, count}, 32'd0);
      q.delete();
      qc.delete();
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Single-stage variant: consumer alternates ready, producer always valid.
      for (int k = 0; k < 8; k++) begin
         step1(1'b1, 8'(8'h60 + k), (k % 2) == 0);
         chk("d1_count_range", {31'd0, s_count <= 1'b1}, 32'd1);
      end
      step1(1'b0, 8'h00, 1'b1);
      chk("d1_drained", q1.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
